// File: rtl/display_bus_pkg.sv
// Shared definitions for the multiplexed BCD display bus (slot codes, digit range, receive FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   SEL_D0/SEL_D1/SEL_BLANK/SEL_D2  slot codes carried on the 2-bit select bus
//   BCD_MAX                         largest legal BCD digit
//   state_t                         receive FSM state (IDLE, GOT0, GOT1)
//   is_bcd()                        range check for a 4-bit digit
package display_bus_pkg;

  // Slot codes. The blank slot sits at 2'b10 so that digit2 is 2'b11;
  // this matches the transmitting multiplexer's scan order 00, 01, 10, 11.
  localparam logic [1:0] SEL_D0    = 2'b00;
  localparam logic [1:0] SEL_D1    = 2'b01;
  localparam logic [1:0] SEL_BLANK = 2'b10;
  localparam logic [1:0] SEL_D2    = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Receive progress through a frame: nothing yet, digit0 held, digit0+1 held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2
  } state_t;

  function automatic logic is_bcd(input logic [3:0] value);
    return (value <= BCD_MAX);
  endfunction

endpackage

// File: rtl/sel_settle.sv
// Select-code glitch filter: emits one sample strobe per stable dwell of the slot code.
// Latency: strobe is combinational in the cycle where the dwell reaches SETTLE cycles.
// Backpressure: none; the scanned bus cannot be stalled.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   sel     in   2-bit slot code from the display bus
//   strobe  out  high in exactly one cycle of every dwell that lasts SETTLE cycles or more
module sel_settle
  import display_bus_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  output logic       strobe
);

  localparam int DW = $clog2(SETTLE + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SETTLE);
  // The register holds the count as of the previous cycle, so the cycle in
  // which the running count reaches SETTLE is the one where it reads SETTLE-1.
  localparam logic [DW-1:0] DWELL_PRE = DW'(SETTLE - 1);

  logic [1:0]    sel_q;
  logic [DW-1:0] dwell;
  logic          changed;

  assign changed = (sel != sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= SEL_BLANK;
      dwell <= '0;
    end else begin
      sel_q <= sel;
      if (changed) begin
        dwell <= DW'(1);
      end else if (dwell != DWELL_MAX) begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // A change cycle counts as dwell 1, so with SETTLE=1 it samples immediately.
  // Saturation at SETTLE keeps a long dwell from firing a second time.
  assign strobe = changed ? (SETTLE == 1) : (dwell == DWELL_PRE);

endmodule

// File: rtl/bcd_scan_demux.sv
// Demultiplexes a scanned 3-digit BCD bus into atomically committed digit registers, flagging order/range errors and stale data.
// Latency: dig*/frame_valid update at the edge ending the digit2 sample cycle; sync_err one edge after the offending sample.
// Backpressure: none; the bus is observed passively and cannot be stalled.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   bcd_in[3:0]  in   multiplexed BCD digit
//   sel[1:0]     in   slot code (00 digit0, 01 digit1, 10 blank, 11 digit2)
//   dig0..dig2   out  last committed frame
//   frame_valid  out  one-cycle pulse per committed frame
//   sync_err     out  one-cycle pulse per sequencing or BCD-range error
//   stale        out  high while no frame has been committed for TIMEOUT cycles
module bcd_scan_demux
  import display_bus_pkg::*;
#(
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd_in,
  input  logic [1:0] sel,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic       frame_valid,
  output logic       sync_err,
  output logic       stale
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  logic          strobe;
  state_t        state;
  state_t        state_nxt;
  logic [3:0]    shadow0;
  logic [3:0]    shadow1;
  logic          cap0;
  logic          cap1;
  logic          commit;
  logic          err;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  sel_settle #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .strobe (strobe)
  );

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cap0      = 1'b0;
    cap1      = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    if (strobe && (sel != SEL_BLANK)) begin
      if (!is_bcd(bcd_in)) begin
        // An out-of-range digit poisons the whole frame regardless of slot.
        err       = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (sel)
          SEL_D0: begin
            // digit0 always restarts a frame; it is only an error if it
            // interrupts one already in progress.
            cap0      = 1'b1;
            state_nxt = GOT0;
            err       = (state != IDLE);
          end
          SEL_D1: begin
            if (state == GOT0) begin
              cap1      = 1'b1;
              state_nxt = GOT1;
            end else begin
              err       = 1'b1;
              state_nxt = IDLE;
            end
          end
          SEL_D2: begin
            if (state == GOT1) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end else begin
              err       = 1'b1;
              state_nxt = IDLE;
            end
          end
          default: begin
            state_nxt = state;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and committed digit registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow0 <= 4'd0;
      shadow1 <= 4'd0;
    end else begin
      if (cap0) shadow0 <= bcd_in;
      if (cap1) shadow1 <= bcd_in;
    end
  end

  // digit2 goes straight from the bus so the whole frame lands in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig0 <= 4'd0;
      dig1 <= 4'd0;
      dig2 <= 4'd0;
    end else if (commit) begin
      dig0 <= shadow0;
      dig1 <= shadow1;
      dig2 <= bcd_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= commit;
      sync_err    <= err;
    end
  end

  // ---------------------------------------------------------------------------
  // Stale timer: counts cycles since the last commit, saturating.
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_nxt = timer;
    if (commit) begin
      timer_nxt = '0;
    end else if (timer != TIMER_MAX) begin
      timer_nxt = timer + TW'(1);
    end
  end

  // stale is registered from the next timer value so it tracks the timer
  // exactly, including dropping on the same edge as a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= TIMER_MAX;
      stale <= 1'b1;
    end else begin
      timer <= timer_nxt;
      stale <= (timer_nxt == TIMER_MAX);
    end
  end

endmodule

// File: tb/tb_bcd_scan_demux.sv
// Self-checking bench: two instances (SETTLE=1 and SETTLE=3, TIMEOUT=8) against a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_scan_demux;

  localparam int SET_A = 1;
  localparam int SET_B = 3;
  localparam int TO    = 8;

  logic       clk;
  logic       reset;
  logic [1:0] sel_i [2];
  logic [3:0] bcd_i [2];
  logic [3:0] d0_o  [2];
  logic [3:0] d1_o  [2];
  logic [3:0] d2_o  [2];
  logic       fv_o  [2];
  logic       er_o  [2];
  logic       st_o  [2];

  int checks;
  int failures;

  bcd_scan_demux #(.SETTLE(SET_A), .TIMEOUT(TO)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_i[0]),
    .sel         (sel_i[0]),
    .dig0        (d0_o[0]),
    .dig1        (d1_o[0]),
    .dig2        (d2_o[0]),
    .frame_valid (fv_o[0]),
    .sync_err    (er_o[0]),
    .stale       (st_o[0])
  );

  bcd_scan_demux #(.SETTLE(SET_B), .TIMEOUT(TO)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_i[1]),
    .sel         (sel_i[1]),
    .dig0        (d0_o[1]),
    .dig1        (d1_o[1]),
    .dig2        (d2_o[1]),
    .frame_valid (fv_o[1]),
    .sync_err    (er_o[1]),
    .stale       (st_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: run length of the current slot code, number of digits
  // collected so far, held digits, and cycles since the last commit.
  // ---------------------------------------------------------------------------
  int run      [2];
  int prev_sel [2];
  int got      [2];
  int held     [2][2];
  int edig     [2][3];
  int efv      [2];
  int eer      [2];
  int since    [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? SET_A : SET_B;
  endfunction

  task automatic model_reset(input int i);
    run[i]      = 0;
    prev_sel[i] = 2;
    got[i]      = 0;
    held[i][0]  = 0;
    held[i][1]  = 0;
    edig[i][0]  = 0;
    edig[i][1]  = 0;
    edig[i][2]  = 0;
    efv[i]      = 0;
    eer[i]      = 0;
    since[i]    = TO;
  endtask

  task automatic model_step(input int i);
    int  s;
    int  b;
    bit  committed;
    s = int'(sel_i[i]);
    b = int'(bcd_i[i]);
    committed = 1'b0;
    if (s != prev_sel[i]) run[i] = 1;
    else if (run[i] < 1000000) run[i] = run[i] + 1;
    prev_sel[i] = s;
    efv[i] = 0;
    eer[i] = 0;
    if (run[i] == settle_of(i) && s != 2) begin
      if (b > 9) begin
        eer[i] = 1;
        got[i] = 0;
      end else if (s == 0) begin
        eer[i]     = (got[i] != 0) ? 1 : 0;
        held[i][0] = b;
        got[i]     = 1;
      end else if (s == 1 && got[i] == 1) begin
        held[i][1] = b;
        got[i]     = 2;
      end else if (s == 3 && got[i] == 2) begin
        edig[i][0] = held[i][0];
        edig[i][1] = held[i][1];
        edig[i][2] = b;
        efv[i]     = 1;
        got[i]     = 0;
        committed  = 1'b1;
      end else begin
        eer[i] = 1;
        got[i] = 0;
      end
    end
    if (committed) since[i] = 0;
    else if (since[i] < 1000000) since[i] = since[i] + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.dig0", i), 32'(d0_o[i]), edig[i][0]);
      chk($sformatf("u%0d.dig1", i), 32'(d1_o[i]), edig[i][1]);
      chk($sformatf("u%0d.dig2", i), 32'(d2_o[i]), edig[i][2]);
      chk($sformatf("u%0d.frame_valid", i), 32'(fv_o[i]), efv[i]);
      chk($sformatf("u%0d.sync_err", i), 32'(er_o[i]), eer[i]);
      chk($sformatf("u%0d.stale", i), 32'(st_o[i]), (since[i] >= TO) ? 1 : 0);
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cyc(input logic [1:0] sa, input logic [3:0] ba,
                     input logic [1:0] sb, input logic [3:0] bb);
    sel_i[0] = sa;
    bcd_i[0] = ba;
    sel_i[1] = sb;
    bcd_i[1] = bb;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) model_reset(i);
      else       model_step(i);
    end
    @(negedge clk);
    check_all();
  endtask

  // Hold one slot on instance i for n cycles; the other instance sits on blank.
  task automatic slot(input int i, input logic [1:0] s, input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      if (i == 0) cyc(s, b, 2'b10, 4'd0);
      else        cyc(2'b10, 4'd0, s, b);
    end
  endtask

  int         rem [2];
  logic [1:0] cs  [2];
  logic [3:0] cb  [2];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sel_i[i] = 2'b10;
      bcd_i[i] = 4'd0;
      model_reset(i);
    end
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("rst.stale", 32'(st_o[0]), 1);
    chk("rst.dig0", 32'(d0_o[1]), 0);
    reset = 1'b0;

    // SETTLE=1 basic frame with a blank slot.
    slot(0, 2'b00, 4'd3, 1);
    slot(0, 2'b01, 4'd5, 1);
    slot(0, 2'b10, 4'd8, 1);
    slot(0, 2'b11, 4'd7, 1);
    chk("t1.dig0", 32'(d0_o[0]), 3);
    chk("t1.dig1", 32'(d1_o[0]), 5);
    chk("t1.dig2", 32'(d2_o[0]), 7);
    chk("t1.fv",   32'(fv_o[0]), 1);
    chk("t1.stale", 32'(st_o[0]), 0);
    slot(0, 2'b10, 4'd0, 1);
    chk("t1.fv_drop", 32'(fv_o[0]), 0);

    // SETTLE=3: a 2-cycle digit1 glitch must not sample.
    slot(1, 2'b00, 4'd4, 3);
    slot(1, 2'b01, 4'd9, 2);
    slot(1, 2'b10, 4'd0, 1);
    slot(1, 2'b01, 4'd6, 3);
    slot(1, 2'b11, 4'd2, 3);
    chk("t2.dig0", 32'(d0_o[1]), 4);
    chk("t2.dig1", 32'(d1_o[1]), 6);
    chk("t2.dig2", 32'(d2_o[1]), 2);
    chk("t2.fv",   32'(fv_o[1]), 1);

    // Out-of-order digit2 after digit0.
    slot(1, 2'b00, 4'd1, 3);
    slot(1, 2'b11, 4'd9, 3);
    chk("t3.err",  32'(er_o[1]), 1);
    chk("t3.fv",   32'(fv_o[1]), 0);
    chk("t3.dig0", 32'(d0_o[1]), 4);
    chk("t3.dig2", 32'(d2_o[1]), 2);

    // Range error in the digit1 slot, then the digit2 slot also errors.
    slot(0, 2'b00, 4'd2, 1);
    slot(0, 2'b01, 4'd12, 1);
    chk("t4.err_range", 32'(er_o[0]), 1);
    slot(0, 2'b11, 4'd5, 1);
    chk("t4.err_seq", 32'(er_o[0]), 1);
    chk("t4.fv", 32'(fv_o[0]), 0);

    // Stale timing around one commit.
    slot(0, 2'b00, 4'd1, 1);
    slot(0, 2'b01, 4'd2, 1);
    slot(0, 2'b11, 4'd3, 1);
    chk("t5.stale_commit", 32'(st_o[0]), 0);
    for (int k = 1; k <= TO; k++) begin
      slot(0, 2'b10, 4'd0, 1);
      chk($sformatf("t5.stale_%0d", k), 32'(st_o[0]), (k == TO) ? 1 : 0);
    end
    slot(0, 2'b00, 4'd4, 1);
    slot(0, 2'b01, 4'd5, 1);
    chk("t5.stale_hold", 32'(st_o[0]), 1);
    slot(0, 2'b11, 4'd6, 1);
    chk("t5.stale_drop", 32'(st_o[0]), 0);
    chk("t5.fv", 32'(fv_o[0]), 1);

    // Asynchronous reset in the middle of a frame.
    slot(0, 2'b00, 4'd1, 1);
    slot(0, 2'b01, 4'd2, 1);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    chk("t6.dig0", 32'(d0_o[0]), 0);
    chk("t6.dig2", 32'(d2_o[0]), 0);
    chk("t6.stale", 32'(st_o[0]), 1);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    slot(0, 2'b11, 4'd4, 1);
    chk("t6.lone_d2", 32'(er_o[0]), 1);
    slot(0, 2'b00, 4'd7, 1);
    slot(0, 2'b01, 4'd8, 1);
    slot(0, 2'b11, 4'd9, 1);
    chk("t6.dig0_new", 32'(d0_o[0]), 7);
    chk("t6.dig1_new", 32'(d1_o[0]), 8);
    chk("t6.dig2_new", 32'(d2_o[0]), 9);

    // Randomized traffic: mostly in-order slots with random dwell lengths,
    // occasional out-of-order codes and out-of-range digits.
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0;
      cs[i]  = 2'b10;
      cb[i]  = 4'd0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          if ($urandom_range(0, 9) < 7) begin
            case (cs[i])
              2'b00:   cs[i] = 2'b01;
              2'b01:   cs[i] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
              2'b10:   cs[i] = 2'b11;
              default: cs[i] = 2'b00;
            endcase
          end else begin
            cs[i] = 2'($urandom_range(0, 3));
          end
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, settle_of(i) + 2))
                                               : settle_of(i);
          cb[i] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 15) == 0) cb[i] = 4'($urandom_range(10, 15));
        else if ($urandom_range(0, 3) == 0) cb[i] = 4'($urandom_range(0, 9));
        rem[i] = rem[i] - 1;
      end
      cyc(cs[0], cb[0], cs[1], cb[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
